slot_reels: RTL and testbench



---
 rtl/slot_pkg.sv | 28 ++
 rtl/slot_reel.sv | 58 +++++
 rtl/slot_reels.sv | 167 ++++++++++++++++
 tb/tb_slot_reels.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// Shared types and constants for the three-reel symbol generator.
package slot_pkg;

   // Controller states shared by the reel block and the game FSM
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SPIN = 2'd1,
      SLOW = 2'd2,
      DONE = 2'd3
   } reel_state_t;

   // LFSR seed and feedback taps (bits 16,14,13,11 counted from 1)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Default reel geometry
   localparam int DEF_NUM_SYMBOLS = 8;
   localparam int DEF_SYM_W       = 3;

   // Remaining-step counters hold at most 8+65+8+65+8 = 154
   localparam int CNT_W = 8;

   // Advance a left-shifting Fibonacci LFSR by one step
   function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/slot_reel.sv
// One reel: symbol register with wrap, remaining-step counter and stopped flag.
// While the counter is zero the reel free-runs on every step (fast spin);
// once loaded with a nonzero count it stops itself after that many steps.
module slot_reel
   import slot_pkg::*;
#(
   parameter int NUM_SYMBOLS = DEF_NUM_SYMBOLS,
   parameter int SYM_W       = DEF_SYM_W
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic             load,
   input  logic [CNT_W-1:0] load_count,
   output logic [SYM_W-1:0] sym,
   output logic             stopped
);

   localparam logic [SYM_W-1:0] LAST_SYM = SYM_W'(NUM_SYMBOLS - 1);

   logic [SYM_W-1:0] r_sym;
   logic [CNT_W-1:0] r_count;
   logic             r_stopped;
   logic [SYM_W-1:0] w_symNext;

   // Next symbol with explicit wrap so non power-of-two reels work
   always_comb begin
      w_symNext = r_sym + SYM_W'(1);
      if (r_sym == LAST_SYM) begin
         w_symNext = '0;
      end
   end

   // Symbol, countdown and stopped flag; the flag rises on the final advance
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sym     <= '0;
         r_count   <= '0;
         r_stopped <= 1'b1;
      end else if (load) begin
         r_count   <= load_count;
         r_stopped <= 1'b0;
      end else if (step) begin
         r_sym <= w_symNext;
         if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
            if (r_count == CNT_W'(1)) begin
               r_stopped <= 1'b1;
            end
         end
      end
   end

   assign sym     = r_sym;
   assign stopped = r_stopped;

endmodule

// File: rtl/slot_reels.sv
// Three-reel symbol generator feeding the slot-machine game FSM.
// Spins all reels fast, then on a stop request slows them and lets each
// reel run a pseudo-random number of extra steps (reel 1 first, reel 3
// last), pulses done and reports whether all three symbols agree.
module slot_reels
   import slot_pkg::*;
#(
   parameter int NUM_SYMBOLS = DEF_NUM_SYMBOLS,
   parameter int SYM_W       = DEF_SYM_W,
   parameter int FAST_DIV    = 2,
   parameter int SLOW_DIV    = 4,
   parameter int STOP_GAP    = 2
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             spin,
   input  logic             stop_req,
   output logic [SYM_W-1:0] c1,
   output logic [SYM_W-1:0] c2,
   output logic [SYM_W-1:0] c3,
   output logic             spinning,
   output logic [2:0]       reel_stopped,
   output logic             done,
   output logic             match
);

   localparam int PSC_W = 16;
   localparam logic [PSC_W-1:0] FAST_LAST = PSC_W'(FAST_DIV - 1);
   localparam logic [PSC_W-1:0] SLOW_LAST = PSC_W'(SLOW_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_STEP  = CNT_W'(STOP_GAP + 1);

   reel_state_t      r_state;
   reel_state_t      w_nextState;
   logic [15:0]      r_lfsr;
   logic [PSC_W-1:0] r_psc;
   logic             r_spinning;
   logic             r_done;
   logic             r_match;

   logic             w_spinAccept;
   logic             w_stopAccept;
   logic             w_fastTick;
   logic             w_slowTick;
   logic             w_finish;
   logic [2:0]       w_stopped;
   logic [2:0]       w_step;
   logic             w_load;
   logic [CNT_W-1:0] w_cnt1;
   logic [CNT_W-1:0] w_cnt2;
   logic [CNT_W-1:0] w_cnt3;
   logic [CNT_W-1:0] w_load1;
   logic [CNT_W-1:0] w_load2;
   logic [CNT_W-1:0] w_load3;
   logic [SYM_W-1:0] w_sym1;
   logic [SYM_W-1:0] w_sym2;
   logic [SYM_W-1:0] w_sym3;

   // Decode accepted commands and prescaler ticks; a stop request wins over
   // a fast tick so the reels never advance on the cycle the spin ends
   always_comb begin
      w_spinAccept = (r_state == IDLE) && spin;
      w_stopAccept = (r_state == SPIN) && stop_req;
      w_fastTick   = (r_state == SPIN) && !stop_req && (r_psc == FAST_LAST);
      w_slowTick   = (r_state == SLOW) && (r_psc == SLOW_LAST);
      w_finish     = (r_state == SLOW) && w_stopped[2];
      w_load       = w_spinAccept || w_stopAccept;
      w_step[0]    = w_fastTick || (w_slowTick && !w_stopped[0]);
      w_step[1]    = w_fastTick || (w_slowTick && !w_stopped[1]);
      w_step[2]    = w_fastTick || (w_slowTick && !w_stopped[2]);
   end

   // Stop distances from the live LFSR; each later reel needs strictly more steps
   always_comb begin
      w_cnt1  = CNT_W'(1) + CNT_W'(r_lfsr[2:0]);
      w_cnt2  = w_cnt1 + GAP_STEP + CNT_W'(r_lfsr[5:3]);
      w_cnt3  = w_cnt2 + GAP_STEP + CNT_W'(r_lfsr[8:6]);
      w_load1 = w_stopAccept ? w_cnt1 : '0;
      w_load2 = w_stopAccept ? w_cnt2 : '0;
      w_load3 = w_stopAccept ? w_cnt3 : '0;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state; DONE follows once reel 3 reports stopped
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (spin)      w_nextState = SPIN;
         SPIN:    if (stop_req)  w_nextState = SLOW;
         SLOW:    if (w_finish)  w_nextState = DONE;
         DONE:                   w_nextState = IDLE;
         default:                w_nextState = IDLE;
      endcase
   end

   // Free-running LFSR, shifts every cycle regardless of state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= lfsrNext(r_lfsr);
      end
   end

   // Shared prescaler; restarts at zero on every spin and stop acceptance
   always_ff @(posedge clk) begin
      if (reset) begin
         r_psc <= '0;
      end else begin
         case (r_state)
            SPIN:    r_psc <= (stop_req || r_psc == FAST_LAST) ? '0 : r_psc + PSC_W'(1);
            SLOW:    r_psc <= (r_psc == SLOW_LAST) ? '0 : r_psc + PSC_W'(1);
            default: r_psc <= '0;
         endcase
      end
   end

   // Status outputs; match is taken from the settled symbols and held until the next spin
   always_ff @(posedge clk) begin
      if (reset) begin
         r_spinning <= 1'b0;
         r_done     <= 1'b0;
         r_match    <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_spinAccept) begin
            r_spinning <= 1'b1;
            r_match    <= 1'b0;
         end else if (w_finish) begin
            r_spinning <= 1'b0;
            r_match    <= (w_sym1 == w_sym2) && (w_sym2 == w_sym3);
         end
      end
   end

   slot_reel #(.NUM_SYMBOLS(NUM_SYMBOLS), .SYM_W(SYM_W)) uReel1 (
      .clk(clk), .reset(reset), .step(w_step[0]), .load(w_load),
      .load_count(w_load1), .sym(w_sym1), .stopped(w_stopped[0])
   );

   slot_reel #(.NUM_SYMBOLS(NUM_SYMBOLS), .SYM_W(SYM_W)) uReel2 (
      .clk(clk), .reset(reset), .step(w_step[1]), .load(w_load),
      .load_count(w_load2), .sym(w_sym2), .stopped(w_stopped[1])
   );

   slot_reel #(.NUM_SYMBOLS(NUM_SYMBOLS), .SYM_W(SYM_W)) uReel3 (
      .clk(clk), .reset(reset), .step(w_step[2]), .load(w_load),
      .load_count(w_load3), .sym(w_sym3), .stopped(w_stopped[2])
   );

   assign c1           = w_sym1;
   assign c2           = w_sym2;
   assign c3           = w_sym3;
   assign spinning     = r_spinning;
   assign reel_stopped = w_stopped;
   assign done         = r_done;
   assign match        = r_match;

endmodule

// File: tb/tb_slot_reels.sv
// Bench for slot_reels: two instances (8 symbols / gap 2 and 2 symbols / gap 1)
// share clock and inputs; expectations come from a game-level arithmetic model.
module tb_slot_reels;

   localparam int FD = 2;
   localparam int SD = 4;

   logic clk = 1'b0;
   logic reset;
   logic spin;
   logic stop_req;

   logic [2:0] a_c1, a_c2, a_c3, a_stopped;
   logic       a_spinning, a_done, a_match;
   logic       b_c1, b_c2, b_c3;
   logic [2:0] b_stopped;
   logic       b_spinning, b_done, b_match;

   logic [15:0] mLfsr;

   int checks   = 0;
   int failures = 0;
   int nSym[2]   = '{8, 2};
   int gapArr[2] = '{2, 1};
   int sym[2][3];
   int matchHeld[2];

   slot_reels #(.NUM_SYMBOLS(8), .SYM_W(3), .FAST_DIV(FD), .SLOW_DIV(SD), .STOP_GAP(2)) dutA (
      .clk(clk), .reset(reset), .spin(spin), .stop_req(stop_req),
      .c1(a_c1), .c2(a_c2), .c3(a_c3), .spinning(a_spinning),
      .reel_stopped(a_stopped), .done(a_done), .match(a_match)
   );

   slot_reels #(.NUM_SYMBOLS(2), .SYM_W(1), .FAST_DIV(FD), .SLOW_DIV(SD), .STOP_GAP(1)) dutB (
      .clk(clk), .reset(reset), .spin(spin), .stop_req(stop_req),
      .c1(b_c1), .c2(b_c2), .c3(b_c3), .spinning(b_spinning),
      .reel_stopped(b_stopped), .done(b_done), .match(b_match)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Reference random source: 16-bit Fibonacci register, taps 16,14,13,11
   always @(posedge clk) begin
      if (reset) mLfsr <= 16'hACE1;
      else       mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
   end

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [31:0] obsVal(input int k, input int f);
      logic [31:0] v;
      v = '0;
      if (k == 0) begin
         case (f)
            0: v = 32'(a_c1);
            1: v = 32'(a_c2);
            2: v = 32'(a_c3);
            3: v = 32'(a_stopped);
            4: v = 32'(a_spinning);
            5: v = 32'(a_done);
            default: v = 32'(a_match);
         endcase
      end else begin
         case (f)
            0: v = 32'(b_c1);
            1: v = 32'(b_c2);
            2: v = 32'(b_c3);
            3: v = 32'(b_stopped);
            4: v = 32'(b_spinning);
            5: v = 32'(b_done);
            default: v = 32'(b_match);
         endcase
      end
      return v;
   endfunction

   task automatic checkVal(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, k, obs, exp);
      end
   endtask

   task automatic checkOutput(input int k, input int e0, input int e1, input int e2,
                              input int eSt, input int eSp, input int eDn, input int eMt);
      checkVal("c1", k, obsVal(k, 0), 32'(e0));
      checkVal("c2", k, obsVal(k, 1), 32'(e1));
      checkVal("c3", k, obsVal(k, 2), 32'(e2));
      checkVal("reel_stopped", k, obsVal(k, 3), 32'(eSt));
      checkVal("spinning", k, obsVal(k, 4), 32'(eSp));
      checkVal("done", k, obsVal(k, 5), 32'(eDn));
      checkVal("match", k, obsVal(k, 6), 32'(eMt));
   endtask

   task automatic checkReset();
      for (int k = 0; k < 2; k++) begin
         checkOutput(k, 0, 0, 0, 7, 0, 0, 0);
         for (int i = 0; i < 3; i++) sym[k][i] = 0;
         matchHeld[k] = 0;
      end
   endtask

   // One full game: idle noise, spin, kSpin fast cycles, stop, slow-down, done.
   // abortAt > 0 asserts reset at that slow-phase cycle instead of finishing.
   task automatic applyStimulus(input int kSpin, input bit sameCycle, input int abortAt);
      int sStop[2][3];
      int r[2][3];
      int fin[2][3];
      int lastM[2];
      int eq[2];
      int capL, pulseM, endM, tk, st;
      int e[3];

      // stop requests in IDLE must change nothing
      for (int j = 0; j < 2; j++) begin
         spin = 1'b0;
         stop_req = 1'($urandom_range(0, 1));
         tick();
         for (int k = 0; k < 2; k++)
            checkOutput(k, sym[k][0], sym[k][1], sym[k][2], 7, 0, 0, matchHeld[k]);
      end

      // spin accepted: SPIN entry, symbols unchanged, match cleared
      spin = 1'b1;
      stop_req = sameCycle;
      tick();
      for (int k = 0; k < 2; k++) begin
         matchHeld[k] = 0;
         checkOutput(k, sym[k][0], sym[k][1], sym[k][2], 0, 1, 0, 0);
      end

      // fast spin: one advance every FD cycles, spin input ignored
      for (int j = 1; j <= kSpin; j++) begin
         spin = 1'($urandom_range(0, 1));
         stop_req = 1'b0;
         tick();
         for (int k = 0; k < 2; k++)
            checkOutput(k, (sym[k][0] + j / FD) % nSym[k], (sym[k][1] + j / FD) % nSym[k],
                        (sym[k][2] + j / FD) % nSym[k], 0, 1, 0, 0);
      end

      // stop request: distances drawn from the current random value
      capL = int'(mLfsr);
      spin = 1'($urandom_range(0, 1));
      stop_req = 1'b1;
      tick();
      for (int k = 0; k < 2; k++) begin
         r[k][0] = 1 + (capL & 7);
         r[k][1] = r[k][0] + gapArr[k] + 1 + ((capL >> 3) & 7);
         r[k][2] = r[k][1] + gapArr[k] + 1 + ((capL >> 6) & 7);
         for (int i = 0; i < 3; i++) begin
            sStop[k][i] = (sym[k][i] + kSpin / FD) % nSym[k];
            fin[k][i]   = (sStop[k][i] + r[k][i]) % nSym[k];
         end
         eq[k]    = (fin[k][0] == fin[k][1] && fin[k][1] == fin[k][2]) ? 1 : 0;
         lastM[k] = r[k][2] * SD + 1;
         checkOutput(k, sStop[k][0], sStop[k][1], sStop[k][2], 0, 1, 0, 0);
      end
      pulseM = (lastM[0] < lastM[1]) ? lastM[0] + 1 : lastM[1] + 1;
      endM   = (lastM[0] > lastM[1]) ? lastM[0] + 2 : lastM[1] + 2;

      // slow-down: a tick every SD cycles, reels drop out in order 1,2,3
      for (int m = 1; m <= endM; m++) begin
         stop_req = 1'($urandom_range(0, 1));
         spin = (m == pulseM);
         if (m == abortAt) begin
            reset = 1'b1;
            spin = 1'b0;
            stop_req = 1'b0;
            tick();
            checkReset();
            reset = 1'b0;
            return;
         end
         tick();
         tk = m / SD;
         for (int k = 0; k < 2; k++) begin
            st = 0;
            for (int i = 0; i < 3; i++) begin
               e[i] = (sStop[k][i] + ((tk < r[k][i]) ? tk : r[k][i])) % nSym[k];
               if (tk >= r[k][i]) st = st | (1 << i);
            end
            if (m < lastM[k])       checkOutput(k, e[0], e[1], e[2], st, 1, 0, 0);
            else if (m == lastM[k]) checkOutput(k, e[0], e[1], e[2], st, 0, 1, eq[k]);
            else                    checkOutput(k, e[0], e[1], e[2], st, 0, 0, eq[k]);
         end
      end

      spin = 1'b0;
      stop_req = 1'b0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 3; i++) sym[k][i] = fin[k][i];
         matchHeld[k] = eq[k];
      end
   endtask

   initial begin
      $display("[TB] slot_reels bench start");
      reset = 1'b1;
      spin = 1'b1;
      stop_req = 1'b0;
      tick();
      tick();
      checkReset();
      reset = 1'b0;
      spin = 1'b0;

      applyStimulus(20, 1'b0, -1);
      applyStimulus(0, 1'b1, -1);
      applyStimulus(10, 1'b0, -1);
      applyStimulus(7, 1'b0, 5);
      applyStimulus(3, 1'b0, -1);
      for (int g = 0; g < 14; g++)
         applyStimulus($urandom_range(0, 24), 1'($urandom_range(0, 1)), -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
